svc_soc_sim_lifecycle: RTL and testbench
========================================

// Module: svc_soc_sim_lifecycle
//
// PURPOSE
// Parametrised run/termination controller for RISC-V SOC simulations and on-target self-test.
// Replaces ad-hoc cycle counters and fixed timeouts with:
// - N halt-request channels and an activity-based watchdog (kicked by CPU retire/IO).
// - An absolute cycle limit and a drain phase that lets peripherals (UART) flush before done.
// Sits beside the CPU/IO-reg bank; its done/reason outputs drive the bench $finish and report.
//
// PARAMETERS
// NUM_HALT        2       number of halt_req channels (>=1), e.g. ebreak, sw-exit
// CNT_W           32      width of cycle_count and internal counters
// WATCHDOG_CYCLES 100000  consecutive RUN cycles without kick -> timeout; 0 disables
// MAX_CYCLES      0       absolute RUN-cycle limit; 0 disables
// DRAIN_CYCLES    16      cycles spent in DRAIN before DONE; 0 = skip drain
//
// PORTS
// clk           in   1                  clock
// rst           in   1                  synchronous active-high reset
// halt_req      in   NUM_HALT           per-channel halt request, sampled in RUN only
// kick          in   1                  activity pulse; clears watchdog idle count
// io_idle       in   1                  peripherals idle (used only with IDLE_WAIT_EN)
// running       out  1                  state == RUN
// draining      out  1                  state == DRAIN
// done          out  1                  state == DONE (sticky until rst)
// reason_valid  out  1                  reason captured (DRAIN or DONE)
// reason        out  RW=$clog2(NUM_HALT+2)  0..NUM_HALT-1 channel; NUM_HALT wdt; NUM_HALT+1 max
// cycle_count   out  CNT_W              RUN cycles elapsed, saturating at all-ones
//
// BEHAVIOUR
// - Reset (rst=1 at edge): state=RUN, cycle_count=0, idle_cnt=0, drain_cnt=0, reason=0,
//   reason_valid=0, done=0, draining=0, running=1 from the following cycle; rst mid-run/drain/done same.
// - FSM: RUN -> DRAIN (DRAIN_CYCLES>0) or RUN -> DONE (DRAIN_CYCLES==0) on halt event;
//   DRAIN -> DONE when drain_cnt==DRAIN_CYCLES-1; DONE terminal.
// - Halt event in RUN at edge t: any halt_req bit, idle_cnt==WATCHDOG_CYCLES-1 && !kick
//   (wdt on), or cycle_count==MAX_CYCLES-1 (max on). State/reason/reason_valid update at t+1.
// - Simultaneous events: lowest halt_req index wins, then watchdog, then max-cycles.
// - Reason captured once; halt_req/kick/timeouts ignored in DRAIN and DONE.
// - cycle_count increments every RUN cycle incl. the halt cycle; frozen in DRAIN/DONE; saturates.
// - idle_cnt: 0 on kick, else +1 in RUN; kick on the would-timeout cycle suppresses timeout.
// - drain_cnt: 0 on DRAIN entry, +1 per DRAIN cycle.
// - All outputs registered; no combinational input->output path.
//
// CONFIGURATION
// SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
//   defined: DRAIN -> DONE requires drain_cnt expired AND io_idle==1 that cycle; drain_cnt saturates
//            while waiting; DRAIN_CYCLES==0 still enters DRAIN and waits for io_idle.
//   undefined: io_idle ignored; behaviour exactly as above.
//
// STRUCTURE
// Package svc_soc_sim_pkg: state_t enum {SIM_RUN, SIM_DRAIN, SIM_DONE};
//   reason helper functions reason_wdt(NUM_HALT), reason_max(NUM_HALT).
// Sub-module svc_soc_sim_wdt: kick/idle counter + timeout strobe (CNT_W, WATCHDOG_CYCLES).
// Top: FSM, priority encoder over halt sources, cycle and drain counters.
//
// TESTING
// 1 halt_req=2'b10 at cycle 50, DRAIN_CYCLES=16 -> draining cycle 51, reason=1,
//   done at cycle 67, cycle_count=51.
// 2 WATCHDOG_CYCLES=100, kick every 50 cycles to 500, then none -> reason=NUM_HALT (2)
//   with cycle_count=600.
// 3 halt_req=2'b11 same cycle as watchdog expiry -> reason=0.
// 4 MAX_CYCLES=1000, WATCHDOG_CYCLES=0, DRAIN_CYCLES=0 -> done at cycle 1000,
//   reason=3, cycle_count=1000.
// 5 rst pulse during DRAIN -> next cycle running=1, reason_valid=0, cycle_count=0.
// 6 IDLE_WAIT_EN, io_idle=0 until 40 cycles into DRAIN -> done one cycle after io_idle rises;
//   without macro done after 16 cycles.

Source files
------------

// File: rtl/svc_soc_sim_lifecycle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : svc_soc_sim_pkg
//  Purpose  : Shared types and helpers for the simulation lifecycle controller.
//             Provides the FSM state encoding and the encodings of the two
//             non-channel halt reasons (watchdog and cycle limit), which sit
//             directly above the halt_req channel indices.
//  Revision : 1.0  initial release
// ============================================================================
package svc_soc_sim_pkg;

    // Lifecycle states: RUN until a halt event, optional DRAIN, then DONE.
    typedef enum logic [1:0] {
        SIM_RUN   = 2'd0,
        SIM_DRAIN = 2'd1,
        SIM_DONE  = 2'd2
    } state_t;

    // Reason code reported for a watchdog timeout.
    function automatic int reason_wdt(input int num_halt);
        return num_halt;
    endfunction

    // Reason code reported when the absolute cycle limit is hit.
    function automatic int reason_max(input int num_halt);
        return num_halt + 1;
    endfunction

endpackage : svc_soc_sim_pkg
`default_nettype wire

// File: rtl/svc_soc_sim_lifecycle_if.sv
`default_nettype none
// ============================================================================
//  Module   : svc_soc_sim_lifecycle_if
//  Purpose  : Request/status bundle between the SoC (CPU, IO-reg bank, bench)
//             and the lifecycle controller.
//  Signals  : halt_req[NUM_HALT], kick, io_idle        master -> slave
//             running, draining, done, reason_valid,
//             reason[RW], cycle_count[CNT_W]           slave  -> master
//  Modports : master (SoC / bench side), slave (controller side)
//  Revision : 1.0  initial release
// ============================================================================
interface svc_soc_sim_lifecycle_if #(
    parameter int NUM_HALT = 2,
    parameter int CNT_W    = 32
);
    localparam int RW = $clog2(NUM_HALT + 2);

    logic [NUM_HALT-1:0] halt_req;
    logic                kick;
    logic                io_idle;
    logic                running;
    logic                draining;
    logic                done;
    logic                reason_valid;
    logic [RW-1:0]       reason;
    logic [CNT_W-1:0]    cycle_count;

    modport master (
        output halt_req, kick, io_idle,
        input  running, draining, done, reason_valid, reason, cycle_count
    );

    modport slave (
        input  halt_req, kick, io_idle,
        output running, draining, done, reason_valid, reason, cycle_count
    );

endinterface : svc_soc_sim_lifecycle_if
`default_nettype wire

// File: rtl/svc_soc_sim_lifecycle_wdt.sv
`default_nettype none
// ============================================================================
//  Module   : svc_soc_sim_wdt
//  Purpose  : Activity watchdog. Counts consecutive RUN cycles without a kick
//             and raises a one-cycle timeout strobe on the cycle where the
//             idle count reaches WATCHDOG_CYCLES-1 and no kick is present.
//             WATCHDOG_CYCLES == 0 removes the counter and ties the strobe low.
//  Ports    : clk, rst         clock, synchronous active-high reset
//             i_run            controller is in RUN (counter only advances here)
//             i_kick           activity pulse, clears the idle count
//             o_timeout        timeout strobe (combinational, consumed by FSM)
//  Revision : 1.0  initial release
// ============================================================================
module svc_soc_sim_wdt #(
    parameter int CNT_W           = 32,
    parameter int WATCHDOG_CYCLES = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_run,
    input  wire logic i_kick,
    output logic      o_timeout
);

    generate
        if (WATCHDOG_CYCLES != 0) begin : g_wdt_on
            localparam logic [CNT_W-1:0] c_idle_last = CNT_W'(WATCHDOG_CYCLES - 1);

            logic [CNT_W-1:0] r_idle_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_idle_cnt <= '0;
                end else if (i_run) begin
                    if (i_kick) begin
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt != '1) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
            end

            // A kick on the would-be expiry cycle wins over the timeout.
            assign o_timeout = i_run && !i_kick && (r_idle_cnt == c_idle_last);
        end else begin : g_wdt_off
            logic w_unused;
            assign w_unused  = &{1'b0, clk, rst, i_run, i_kick};
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule : svc_soc_sim_wdt
`default_nettype wire

// File: rtl/svc_soc_sim_lifecycle.sv
`default_nettype none
// ============================================================================
//  Module   : svc_soc_sim_lifecycle
//  Purpose  : Run/termination controller for SoC simulation and on-target
//             self-test. Watches NUM_HALT halt-request channels, an activity
//             watchdog and an absolute cycle limit; on the first event it
//             latches a reason code, optionally drains for DRAIN_CYCLES so
//             peripherals can flush, and then parks in a sticky DONE.
//  Ports    : clk, rst         clock, synchronous active-high reset
//             bus (slave)      halt_req/kick/io_idle in;
//                              running/draining/done/reason_valid/reason/
//                              cycle_count out (all registered)
//  Config   : SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
//             defined  : leaving DRAIN also requires io_idle; the drain count
//                        holds at its last value while waiting, and DRAIN is
//                        entered even when DRAIN_CYCLES == 0.
//             undefined: io_idle is ignored.
//  Reasons  : 0..NUM_HALT-1 channel, NUM_HALT watchdog, NUM_HALT+1 cycle limit
//  Revision : 1.0  initial release
// ============================================================================
module svc_soc_sim_lifecycle
    import svc_soc_sim_pkg::*;
#(
    parameter int NUM_HALT        = 2,
    parameter int CNT_W           = 32,
    parameter int WATCHDOG_CYCLES = 100000,
    parameter int MAX_CYCLES      = 0,
    parameter int DRAIN_CYCLES    = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    svc_soc_sim_lifecycle_if.slave   bus
);

    localparam int RW = $clog2(NUM_HALT + 2);

    localparam logic [RW-1:0]    c_reason_wdt = RW'(reason_wdt(NUM_HALT));
    localparam logic [RW-1:0]    c_reason_max = RW'(reason_max(NUM_HALT));
    localparam logic [CNT_W-1:0] c_max_last   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic             c_max_en     = (MAX_CYCLES != 0);
    localparam logic             c_drain_zero = (DRAIN_CYCLES == 0);

`ifdef SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
    // DRAIN is always visited so the io_idle handshake is honoured.
    localparam logic             c_use_drain  = 1'b1;
`else
    localparam logic             c_use_drain  = !c_drain_zero;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [RW-1:0]    r_reason;
    logic             r_reason_valid;
    logic             r_running;
    logic             r_draining;
    logic             r_done;

    logic             w_in_run;
    logic             w_wdt_timeout;
    logic             w_max_hit;
    logic             w_halt_any;
    logic [RW-1:0]    w_halt_idx;
    logic             w_event;
    logic [RW-1:0]    w_event_reason;
    logic             w_drain_last;
    logic             w_drain_exit;
    logic             w_drain_adv;

    assign w_in_run = (r_state == SIM_RUN);

    svc_soc_sim_wdt #(
        .CNT_W           (CNT_W),
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .i_run     (w_in_run),
        .i_kick    (bus.kick),
        .o_timeout (w_wdt_timeout)
    );

    // Priority: lowest halt channel, then watchdog, then cycle limit.
    always_comb begin
        w_halt_idx = '0;
        for (int i = NUM_HALT - 1; i >= 0; i--) begin
            if (bus.halt_req[i]) begin
                w_halt_idx = RW'(i);
            end
        end
    end

    assign w_halt_any = |bus.halt_req;
    assign w_max_hit  = c_max_en && (r_cycle_count == c_max_last);
    assign w_event    = w_halt_any || w_wdt_timeout || w_max_hit;

    always_comb begin
        w_event_reason = c_reason_max;
        if (w_halt_any) begin
            w_event_reason = w_halt_idx;
        end else if (w_wdt_timeout) begin
            w_event_reason = c_reason_wdt;
        end
    end

    assign w_drain_last = c_drain_zero || (r_drain_cnt == c_drain_last);

`ifdef SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
    // The drain count holds at its last value while peripherals are busy.
    assign w_drain_exit = w_drain_last && bus.io_idle;
    assign w_drain_adv  = !w_drain_last;
`else
    logic w_unused_io_idle;
    assign w_unused_io_idle = bus.io_idle;
    assign w_drain_exit     = w_drain_last;
    assign w_drain_adv      = 1'b1;
`endif

    // Lifecycle FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= SIM_RUN;
            r_cycle_count  <= '0;
            r_drain_cnt    <= '0;
            r_reason       <= '0;
            r_reason_valid <= 1'b0;
            r_running      <= 1'b1;
            r_draining     <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                SIM_RUN: begin
                    // The halt cycle itself still counts as a RUN cycle.
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    if (w_event) begin
                        r_reason       <= w_event_reason;
                        r_reason_valid <= 1'b1;
                        r_running      <= 1'b0;
                        r_drain_cnt    <= '0;
                        if (c_use_drain) begin
                            r_state    <= SIM_DRAIN;
                            r_draining <= 1'b1;
                        end else begin
                            r_state    <= SIM_DONE;
                            r_done     <= 1'b1;
                        end
                    end
                end
                SIM_DRAIN: begin
                    if (w_drain_exit) begin
                        r_state    <= SIM_DONE;
                        r_draining <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_drain_adv) begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                SIM_DONE: begin
                    // Terminal until reset.
                end
                default: begin
                    r_state    <= SIM_DONE;
                    r_running  <= 1'b0;
                    r_draining <= 1'b0;
                    r_done     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.running      = r_running;
    assign bus.draining     = r_draining;
    assign bus.done         = r_done;
    assign bus.reason_valid = r_reason_valid;
    assign bus.reason       = r_reason;
    assign bus.cycle_count  = r_cycle_count;

endmodule : svc_soc_sim_lifecycle
`default_nettype wire

// File: tb/tb_svc_soc_sim_lifecycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_svc_soc_sim_lifecycle
//  Purpose  : Directed self-checking bench for the lifecycle controller.
//             dut_a: NUM_HALT=2, WATCHDOG_CYCLES=100, MAX_CYCLES=0, DRAIN=16
//             dut_b: NUM_HALT=2, WATCHDOG_CYCLES=0, MAX_CYCLES=1000, DRAIN=0
//             "Cycle n" means n rising edges after the reset edge; inputs
//             are changed and outputs sampled 1 time unit after an edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_svc_soc_sim_lifecycle;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    svc_soc_sim_lifecycle_if #(.NUM_HALT(2), .CNT_W(32)) bus_a ();
    svc_soc_sim_lifecycle_if #(.NUM_HALT(2), .CNT_W(32)) bus_b ();

    svc_soc_sim_lifecycle #(
        .NUM_HALT        (2),
        .CNT_W           (32),
        .WATCHDOG_CYCLES (100),
        .MAX_CYCLES      (0),
        .DRAIN_CYCLES    (16)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    svc_soc_sim_lifecycle #(
        .NUM_HALT        (2),
        .CNT_W           (32),
        .WATCHDOG_CYCLES (0),
        .MAX_CYCLES      (1000),
        .DRAIN_CYCLES    (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_a.halt_req = 2'b00;
        bus_a.kick     = 1'b0;
        bus_a.io_idle  = 1'b1;
        bus_b.halt_req = 2'b00;
        bus_b.kick     = 1'b0;
        bus_b.io_idle  = 1'b1;
        step(2);

        // ---- reset state ------------------------------------------------
        do_reset();
        chk("rst_running",  bus_a.running,      1);
        chk("rst_draining", bus_a.draining,     0);
        chk("rst_done",     bus_a.done,         0);
        chk("rst_rvalid",   bus_a.reason_valid, 0);
        chk("rst_reason",   bus_a.reason,       0);
        chk("rst_count",    bus_a.cycle_count,  0);

        // ---- cycle limit 1000, no drain (dut_b) -------------------------
        step(999);
        chk("max_pre_running", bus_b.running,     1);
        chk("max_pre_count",   bus_b.cycle_count, 999);
        step(1);
`ifdef SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
        // Drain is still visited and exits at once because io_idle is high.
        chk("max_draining", bus_b.draining,     1);
        chk("max_reason",   bus_b.reason,       3);
        chk("max_count",    bus_b.cycle_count,  1000);
        step(1);
        chk("max_done",     bus_b.done,         1);
`else
        chk("max_done",     bus_b.done,         1);
        chk("max_draining", bus_b.draining,     0);
        chk("max_reason",   bus_b.reason,       3);
        chk("max_count",    bus_b.cycle_count,  1000);
`endif
        chk("max_rvalid",   bus_b.reason_valid, 1);
        chk("max_running",  bus_b.running,      0);

        // ---- halt channel 1 at cycle 50, 16-cycle drain ------------------
        do_reset();
        step(50);
        chk("h1_pre_count", bus_a.cycle_count, 50);
        bus_a.halt_req = 2'b10;
        step(1);
        bus_a.halt_req = 2'b00;
        chk("h1_draining", bus_a.draining,     1);
        chk("h1_running",  bus_a.running,      0);
        chk("h1_reason",   bus_a.reason,       1);
        chk("h1_rvalid",   bus_a.reason_valid, 1);
        chk("h1_count",    bus_a.cycle_count,  51);
        step(15);
        chk("h1_c66_done",     bus_a.done,     0);
        chk("h1_c66_draining", bus_a.draining, 1);
        step(1);
        chk("h1_c67_done",     bus_a.done,        1);
        chk("h1_c67_draining", bus_a.draining,    0);
        chk("h1_c67_count",    bus_a.cycle_count, 51);
        // Requests after DONE must not disturb the captured reason.
        bus_a.halt_req = 2'b01;
        step(2);
        bus_a.halt_req = 2'b00;
        chk("h1_sticky_reason", bus_a.reason, 1);
        chk("h1_sticky_done",   bus_a.done,   1);

        // ---- watchdog: kicks at cycles 49,99..499, then silence ----------
        do_reset();
        step(49);
        bus_a.kick = 1'b1;
        step(1);
        bus_a.kick = 1'b0;
        repeat (9) begin
            step(49);
            bus_a.kick = 1'b1;
            step(1);
            bus_a.kick = 1'b0;
        end
        chk("wdt_c500_count", bus_a.cycle_count, 500);
        step(99);
        chk("wdt_c599_running", bus_a.running, 1);
        step(1);
        chk("wdt_draining", bus_a.draining,    1);
        chk("wdt_reason",   bus_a.reason,      2);
        chk("wdt_count",    bus_a.cycle_count, 600);

        // ---- halt 2'b11 on the watchdog expiry edge: channel 0 wins -------
        do_reset();
        step(99);
        bus_a.halt_req = 2'b11;
        step(1);
        bus_a.halt_req = 2'b00;
        chk("prio_reason", bus_a.reason,      0);
        chk("prio_count",  bus_a.cycle_count, 100);

        // ---- kick on the would-timeout cycle suppresses the timeout ------
        do_reset();
        step(99);
        bus_a.kick = 1'b1;
        step(1);
        bus_a.kick = 1'b0;
        chk("kick_sup_running", bus_a.running, 1);
        step(99);
        chk("kick_sup_c199_running", bus_a.running, 1);
        step(1);
        chk("kick_sup_reason", bus_a.reason,      2);
        chk("kick_sup_count",  bus_a.cycle_count, 200);

        // ---- reset pulse during DRAIN ------------------------------------
        step(5);
        chk("rd_pre_draining", bus_a.draining, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rd_running",  bus_a.running,      1);
        chk("rd_rvalid",   bus_a.reason_valid, 0);
        chk("rd_count",    bus_a.cycle_count,  0);
        chk("rd_draining", bus_a.draining,     0);
        step(1);
        chk("rd_count_next", bus_a.cycle_count, 1);

        // ---- io_idle low until 40 cycles into DRAIN ----------------------
        do_reset();
        bus_a.io_idle = 1'b0;
        step(10);
        bus_a.halt_req = 2'b01;
        step(1);
        bus_a.halt_req = 2'b00;
        chk("iw_draining", bus_a.draining, 1);
        step(16);
`ifdef SVC_SOC_SIM_LIFECYCLE_IDLE_WAIT_EN
        chk("iw_c27_done", bus_a.done, 0);
        step(24);
        chk("iw_c51_draining", bus_a.draining, 1);
        bus_a.io_idle = 1'b1;
        step(1);
        chk("iw_c52_done", bus_a.done, 1);
`else
        chk("iw_c27_done", bus_a.done, 1);
        step(24);
        bus_a.io_idle = 1'b1;
        step(1);
        chk("iw_c52_done", bus_a.done, 1);
`endif
        chk("iw_reason", bus_a.reason,      0);
        chk("iw_count",  bus_a.cycle_count, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_svc_soc_sim_lifecycle
`default_nettype wire
